// File: rtl/ctrl_sequencer_if.sv
// ctrl_sequencer_if
//   Control bundle between the instruction sequencer and its environment
//   (instruction source, register file, ALU, G register, external data).
//   Clock and reset are not part of the bundle.
//
//   PEIn     execute request (into the sequencer)
//   INSTR    instruction word (into the sequencer)
//   IRld     load pulse to the external instruction register
//   Extrn    external data drives the bus
//   ENW/WRA  register file write enable / address
//   ENR0/RDA0 read port 0 enable / address (Q0 drives the bus)
//   ENR1/RDA1 read port 1 enable / address (Q1 is ALU operand B)
//   Ain      latch bus into ALU A register
//   Gin      latch ALU result into G
//   Gout     G drives the bus
//   ALUcont  ALU operation select
//   Busy     sequencer is mid-instruction
//   Done     one-cycle instruction completion pulse
//
//   master: the sequencer.  slave: whoever drives requests and consumes controls.
interface ctrl_sequencer_if #(
    parameter int DATA_W = 10,
    parameter int OP_W   = 4
);
    logic              PEIn;
    logic [DATA_W-1:0] INSTR;
    logic              IRld;
    logic              Extrn;
    logic              ENW;
    logic [1:0]        WRA;
    logic              ENR0;
    logic [1:0]        RDA0;
    logic              ENR1;
    logic [1:0]        RDA1;
    logic              Ain;
    logic              Gin;
    logic              Gout;
    logic [OP_W-1:0]   ALUcont;
    logic              Busy;
    logic              Done;

    modport master (
        input  PEIn, INSTR,
        output IRld, Extrn, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               Ain, Gin, Gout, ALUcont, Busy, Done
    );

    modport slave (
        output PEIn, INSTR,
        input  IRld, Extrn, ENW, WRA, ENR0, RDA0, ENR1, RDA1,
               Ain, Gin, Gout, ALUcont, Busy, Done
    );
endinterface

// File: rtl/ctrl_sequencer.sv
// ctrl_sequencer
//   Multi-cycle control unit for the 10-bit datapath. Captures an instruction
//   on an execute request and walks a T1..T3 timing FSM, producing every
//   control input of the 4x10 register file, the ALU, the G register and the
//   external-data bus gate.
//
//   Ports:
//     CLKb  clock; all flops update on the falling edge (matches the regfile)
//     RSTb  asynchronous active-low reset
//     bus   ctrl_sequencer_if.master: PEIn/INSTR in, all controls out
//
//   Instruction fields: [9:8]=Rx, [7:6]=Ry, [5:4] reserved, [3:0]=opcode.
//   Only state and irq are stored; outputs decode combinationally.
module ctrl_sequencer #(
    parameter int DATA_W = 10,
    parameter int OP_W   = 4
) (
    input logic              CLKb,
    input logic              RSTb,
    ctrl_sequencer_if.master bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        T1   = 2'd1,
        T2   = 2'd2,
        T3   = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] irq;

    logic [1:0]      rx;
    logic [1:0]      ry;
    logic [OP_W-1:0] op;
    logic            is_load;
    logic            is_copy;
    logic            is_bin;
    logic            is_un;
    logic            unused_rsvd;

    assign rx          = irq[DATA_W-1 -: 2];
    assign ry          = irq[DATA_W-3 -: 2];
    assign op          = irq[OP_W-1:0];
    assign unused_rsvd = ^irq[DATA_W-5 -: 2];

    always_comb begin
        is_load = 1'b0;
        is_copy = 1'b0;
        is_bin  = 1'b0;
        is_un   = 1'b0;
        case (op)
            4'b0000: is_load = 1'b1;
            4'b0001: is_copy = 1'b1;
            4'b0010, 4'b0011, 4'b0110, 4'b0111, 4'b1000: is_bin = 1'b1;
            4'b0100, 4'b0101: is_un = 1'b1;
            default: ;
        endcase
    end

    always_ff @(negedge CLKb or negedge RSTb) begin
        if (!RSTb) begin
            state <= IDLE;
            irq   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.PEIn) begin
                        irq   <= bus.INSTR;
                        state <= T1;
                    end
                end
                T1:      state <= (is_bin || is_un) ? T2 : IDLE;
                T2:      state <= T3;
                T3:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        bus.IRld    = 1'b0;
        bus.Extrn   = 1'b0;
        bus.ENW     = 1'b0;
        bus.WRA     = '0;
        bus.ENR0    = 1'b0;
        bus.RDA0    = '0;
        bus.ENR1    = 1'b0;
        bus.RDA1    = '0;
        bus.Ain     = 1'b0;
        bus.Gin     = 1'b0;
        bus.Gout    = 1'b0;
        bus.ALUcont = '0;
        bus.Busy    = 1'b0;
        bus.Done    = 1'b0;
        case (state)
            // IRld is the only output reachable from inputs alone, so it is
            // gated by RSTb directly; everything else is already 0 in IDLE.
            IDLE: bus.IRld = bus.PEIn & RSTb;
            T1: begin
                bus.Busy = 1'b1;
                if (is_load) begin
                    bus.Extrn = 1'b1;
                    bus.ENW   = 1'b1;
                    bus.WRA   = rx;
                    bus.Done  = 1'b1;
                end else if (is_copy) begin
                    bus.ENR0 = 1'b1;
                    bus.RDA0 = ry;
                    bus.ENW  = 1'b1;
                    bus.WRA  = rx;
                    bus.Done = 1'b1;
                end else if (is_bin || is_un) begin
                    bus.ENR0 = 1'b1;
                    bus.RDA0 = rx;
                    bus.Ain  = 1'b1;
                end else begin
                    bus.Done = 1'b1;
                end
            end
            T2: begin
                bus.Busy    = 1'b1;
                bus.Gin     = 1'b1;
                bus.ALUcont = op;
                if (is_bin) begin
                    bus.ENR1 = 1'b1;
                    bus.RDA1 = ry;
                end
            end
            T3: begin
                bus.Busy = 1'b1;
                bus.Gout = 1'b1;
                bus.ENW  = 1'b1;
                bus.WRA  = rx;
                bus.Done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// tb_ctrl_sequencer
//   Table of per-cycle {PEIn, INSTR, expected outputs} records plus a
//   hand-written mid-instruction reset sequence. Expected outputs are queued
//   when a stimulus cycle is driven and popped when outputs are sampled.
//   Inputs change on the rising edge; outputs are sampled 2 time units later,
//   well away from the active falling edge.
module tb_ctrl_sequencer;

    logic CLKb = 1'b1;
    logic RSTb = 1'b0;

    always #5 CLKb = ~CLKb;

    ctrl_sequencer_if #(.DATA_W(10), .OP_W(4)) sif ();

    ctrl_sequencer #(.DATA_W(10), .OP_W(4)) dut (
        .CLKb (CLKb),
        .RSTb (RSTb),
        .bus  (sif.master)
    );

    // Field order for hex dumps: irld extrn enw wra enr0 rda0 enr1 rda1
    // ain gin gout alucont busy done
    typedef struct packed {
        logic       irld;
        logic       extrn;
        logic       enw;
        logic [1:0] wra;
        logic       enr0;
        logic [1:0] rda0;
        logic       enr1;
        logic [1:0] rda1;
        logic       ain;
        logic       gin;
        logic       gout;
        logic [3:0] alucont;
        logic       busy;
        logic       done;
    } out_t;

    typedef struct {
        logic       pein;
        logic [9:0] instr;
        out_t       exp;
        string      name;
    } vec_t;

    vec_t vecs[$];
    out_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   enw_in_rst = 0;

    always @(sif.ENW or RSTb)
        if (!RSTb && sif.ENW === 1'b1) enw_in_rst++;

    function automatic out_t o_idle(input logic irld);
        out_t o = '0;
        o.irld = irld;
        return o;
    endfunction

    function automatic out_t o_load(input logic [1:0] wra);
        out_t o = '0;
        o.extrn = 1; o.enw = 1; o.wra = wra; o.busy = 1; o.done = 1;
        return o;
    endfunction

    function automatic out_t o_copy(input logic [1:0] rda0, input logic [1:0] wra);
        out_t o = '0;
        o.enr0 = 1; o.rda0 = rda0; o.enw = 1; o.wra = wra; o.busy = 1; o.done = 1;
        return o;
    endfunction

    function automatic out_t o_t1(input logic [1:0] rda0);
        out_t o = '0;
        o.enr0 = 1; o.rda0 = rda0; o.ain = 1; o.busy = 1;
        return o;
    endfunction

    function automatic out_t o_t2(input logic enr1, input logic [1:0] rda1, input logic [3:0] alu);
        out_t o = '0;
        o.enr1 = enr1; o.rda1 = rda1; o.alucont = alu; o.gin = 1; o.busy = 1;
        return o;
    endfunction

    function automatic out_t o_t3(input logic [1:0] wra);
        out_t o = '0;
        o.gout = 1; o.enw = 1; o.wra = wra; o.busy = 1; o.done = 1;
        return o;
    endfunction

    function automatic out_t o_nop();
        out_t o = '0;
        o.busy = 1; o.done = 1;
        return o;
    endfunction

    function automatic out_t actual();
        out_t o;
        o.irld = sif.IRld;   o.extrn = sif.Extrn; o.enw = sif.ENW;   o.wra = sif.WRA;
        o.enr0 = sif.ENR0;   o.rda0 = sif.RDA0;   o.enr1 = sif.ENR1; o.rda1 = sif.RDA1;
        o.ain = sif.Ain;     o.gin = sif.Gin;     o.gout = sif.Gout;
        o.alucont = sif.ALUcont; o.busy = sif.Busy; o.done = sif.Done;
        return o;
    endfunction

    task automatic add(input logic pein, input logic [9:0] instr, input out_t exp, input string name);
        vec_t v;
        v.pein = pein; v.instr = instr; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic compare(input string name);
        out_t e;
        out_t a;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            a = actual();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: actual=%05h required=%05h (t=%0t)", name, a, e, $time);
            end
        end
    endtask

    task automatic expect_now(input out_t exp, input string name);
        exp_q.push_back(exp);
        compare(name);
    endtask

    task automatic apply(input logic pein, input logic [9:0] instr, input out_t exp, input string name);
        @(posedge CLKb);
        sif.PEIn  = pein;
        sif.INSTR = instr;
        exp_q.push_back(exp);
        #2;
        compare(name);
    endtask

    localparam logic [9:0] SUB12  = 10'b01_10_00_0011;
    localparam logic [9:0] LOADR1 = 10'b01_00_00_0000;

    initial begin
        // LOAD R2
        add(1, 10'b10_00_00_0000, o_idle(1),   "load_irld");
        add(0, 10'b11_11_11_1111, o_load(2),   "load_t1");
        add(0, 10'b00_00_00_0000, o_idle(0),   "load_idle");
        // COPY R1 <- R3, INSTR scrambled after capture
        add(1, 10'b01_11_00_0001, o_idle(1),   "copy_irld");
        add(0, 10'b10_10_11_0010, o_copy(3, 1),"copy_t1");
        add(0, 10'b00_00_00_0000, o_idle(0),   "copy_idle");
        // ADD R0,R1
        add(1, 10'b00_01_00_0010, o_idle(1),   "add_irld");
        add(0, 10'b11_11_00_0000, o_t1(0),     "add_t1");
        add(0, 10'b00_00_00_0000, o_t2(1, 1, 4'b0010), "add_t2");
        add(0, 10'b00_00_00_0000, o_t3(0),     "add_t3");
        add(0, 10'b00_00_00_0000, o_idle(0),   "add_idle");
        // INV R3 with a PEIn pulse in T2 that must be ignored
        add(1, 10'b11_00_00_0100, o_idle(1),   "inv_irld");
        add(0, 10'b00_00_00_0000, o_t1(3),     "inv_t1");
        add(1, 10'b00_00_00_0000, o_t2(0, 0, 4'b0100), "inv_t2_pein");
        add(0, 10'b00_00_00_0000, o_t3(3),     "inv_t3");
        add(0, 10'b00_00_00_0000, o_idle(0),   "inv_idle");
        // XOR R3,R2
        add(1, 10'b11_10_00_1000, o_idle(1),   "xor_irld");
        add(0, 10'b00_00_00_0000, o_t1(3),     "xor_t1");
        add(0, 10'b00_00_00_0000, o_t2(1, 2, 4'b1000), "xor_t2");
        add(0, 10'b00_00_00_0000, o_t3(3),     "xor_t3");
        add(0, 10'b00_00_00_0000, o_idle(0),   "xor_idle");
        // FLIP R1 with nonzero Ry: RDA1 must stay 0
        add(1, 10'b01_10_00_0101, o_idle(1),   "flip_irld");
        add(0, 10'b00_00_00_0000, o_t1(1),     "flip_t1");
        add(0, 10'b00_00_00_0000, o_t2(0, 0, 4'b0101), "flip_t2");
        add(0, 10'b00_00_00_0000, o_t3(1),     "flip_t3");
        add(0, 10'b00_00_00_0000, o_idle(0),   "flip_idle");
        // Illegal 1111 with PEIn held high, then LOAD R1 back to back
        add(1, 10'b10_01_00_1111, o_idle(1),   "ill15_irld");
        add(1, LOADR1,            o_nop(),     "ill15_t1");
        add(1, LOADR1,            o_idle(1),   "b2b_irld");
        add(0, 10'b00_00_00_0000, o_load(1),   "b2b_load_t1");
        add(0, 10'b00_00_00_0000, o_idle(0),   "b2b_idle");
        // Illegal 1001 (lowest illegal) with reserved bits set
        add(1, 10'b00_00_11_1001, o_idle(1),   "ill9_irld");
        add(0, 10'b00_00_00_0000, o_nop(),     "ill9_t1");
        add(0, 10'b00_00_00_0000, o_idle(0),   "ill9_idle");
        // LOAD R3 with reserved bits set; COPY with Rx==Ry
        add(1, 10'b11_00_11_0000, o_idle(1),   "loadr3_irld");
        add(0, 10'b00_00_00_0000, o_load(3),   "loadr3_t1");
        add(1, 10'b10_10_00_0001, o_idle(1),   "copy22_irld");
        add(0, 10'b00_00_00_0000, o_copy(2, 2),"copy22_t1");
        add(0, 10'b00_00_00_0000, o_idle(0),   "copy22_idle");

        // Reset held with PEIn high: IRld forced 0
        sif.PEIn  = 1'b1;
        sif.INSTR = 10'b10_00_00_0000;
        #2;
        expect_now(o_idle(0), "reset_irld_forced");
        @(posedge CLKb);
        RSTb     = 1'b1;
        sif.PEIn = 1'b0;
        #2;
        expect_now(o_idle(0), "reset_state");

        for (int i = 0; i < vecs.size(); i++)
            apply(vecs[i].pein, vecs[i].instr, vecs[i].exp, vecs[i].name);

        // SUB R1,R2 with reset asserted in the middle of T2
        apply(1, SUB12,  o_idle(1),             "sub_irld");
        apply(0, '0,     o_t1(1),               "sub_t1");
        apply(1, LOADR1, o_t2(1, 2, 4'b0011),   "sub_t2");
        #1 RSTb = 1'b0;
        #1;
        expect_now(o_idle(0), "rst_async");
        @(negedge CLKb);
        #1;
        expect_now(o_idle(0), "rst_hold");
        @(posedge CLKb);
        RSTb     = 1'b1;
        sif.PEIn = 1'b0;
        #2;
        expect_now(o_idle(0), "rst_release");
        apply(0, '0, o_idle(0), "rst_no_t3");
        apply(0, '0, o_idle(0), "rst_still_idle");

        checks++;
        if (enw_in_rst != 0) begin
            errors++;
            $display("FAIL enw_during_reset: actual=%0d required=0", enw_in_rst);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
